arp_rx_multi: RTL
=================

Name: arp_rx_multi

Overview:
Parametrised ARP receive matcher for the Ethernet core's RX path; it sits beside the other RX matchers on the same byte stream and CRC flags. It answers requests for any of N_IP local IPv4 addresses and reports which address matched. It forwards sender MAC+IP bytes to the ARP transmitter over an arp_bus that carries that match index. Optionally it reports sender MAC/IP from ARP replies addressed to us, for a downstream ARP cache.

Parameters:
N_IP, 2, number of local IPv4 addresses, 1..4
IDX_W, 2, width of match index, >= max(1, clog2(N_IP))
IP_INIT, {4{8'd192,8'd168,8'd7,8'd2}}, 128 bits, entry k at bits [32k+31:32k], reset contents of IP table
LEARN, 1, 1 = enable learn_* outputs on ARP replies; 0 = learn_strobe tied 0

Ports:
clk  in  1  RX clock, timespec 6.8 ns
rst  in  1  synchronous, active-high reset
data  in  8  RX octet, byte 0 = first destination-MAC octet
h_data  in  1  high for the whole packet body
crc_strobe  in  1  one cycle, one clock after h_data falls
crc_ok  in  1  valid with crc_strobe
cfg_we  in  1  IP table write enable
cfg_addr  in  IDX_W+2  {entry, octet}, octet 0 = most significant
cfg_data  in  8  IP table write data
arp_bus  out  11+IDX_W  {ok, strobe, write, data[7:0], idx}
learn_strobe  out  1  one-cycle pulse, valid learned pair
learn_mac  out  48  sender MAC of learned reply
learn_ip  out  32  sender IP of learned reply

Behaviour:
- Reset values: all outputs 0; IP table = IP_INIT; per-packet state cleared; pending config write cleared.
- pack_cnt: counts octets while h_data=1 and saturates at 63; cleared while h_data=0.
- Template check, any mismatch clears keep:
  - bytes 12..13 = 08 06; 14..15 = 00 01; 16..17 = 08 00; 18 = 06; 19 = 04.
  - byte 20 = 00; byte 21 = 01 (request) or 02 (reply); this is latched as is_reply.
- keep is set on the first h_data cycle (h_data & !h_data1).
- Per-entry match vector m[N_IP-1:0]: set at packet start. Entry k clears if any TPA byte (38..41) differs from its table octet.
- Bytes 22..31 (SHA then SPA): write=1 with data = that byte, delayed exactly 2 clocks from data input; 10 consecutive write cycles.
  - write is asserted only while keep=1 and is_reply=0.
  - SHA and SPA are captured into a 80-bit register on every packet.
- idx = lowest set bit of m, registered; held stable from byte 42 until the next packet start.
- Response decision on the cycle after crc_strobe, only if keep=1, |m=1 and pack_cnt reached >= 42:
  - request (is_reply=0): strobe=1 for one cycle; ok=crc_ok (registered).
  - reply with LEARN=1: learn_strobe=1 only if crc_ok=1; learn_mac/learn_ip = captured SHA/SPA, held until the next learn_strobe.
- Short packets (h_data falls before byte 42): no strobe and no learn; any write pulses already issued are harmless, and arp_tx ignores them without strobe.
- crc_strobe without a preceding packet: no output.
- Config writes:
  - With h_data=0, a write lands on the next clock.
  - With h_data=1, the write is held in a one-entry pending register and applied on the first clock with h_data=0.
  - A second write while pending overwrites the pending one.
  - A packet always compares against the table as it was at packet start.
- rst mid-packet: all state cleared; the remainder of that packet is ignored (keep=0) until h_data has been low at least one cycle.
- Back-to-back packets with one idle cycle between them: handled; decision state for packet n is consumed by its crc_strobe before byte 12 of packet n+1.

Decomposition:
- Shared package (arp_pkg): ARP byte offsets (ETHERTYPE_OFF=12, OPER_OFF=20, SHA_OFF=22, SPA_OFF=28, TPA_OFF=38, MIN_LEN=42), template constants, and arp_bus field positions, shared with arp_tx.
- Sub-module arp_ip_table: N_IP×4 octet register file with the deferred-write logic, a combinational per-entry compare against an octet index, and the m-vector output.

Test Plan:
- Request for 192.168.7.2 (entry 0, default table), crc_ok=1 → 10 write cycles carrying SHA/SPA bytes 2 clocks late; strobe=1 and ok=1 one cycle after crc_strobe; idx=0.
- Entry 1 written to 10.0.0.5 via cfg, then a request for 10.0.0.5 → strobe, ok=1, idx=1. A request for 10.0.0.6 → no strobe.
- Reply (op=02) to 192.168.7.2 from 02:00:00:00:00:07 / 192.168.7.9 with LEARN=1 → learn_strobe, learn_mac=48'h020000000007, learn_ip=32'hC0A80709; no write, no strobe.
- Matching request with crc_ok=0 → strobe=1, ok=0. Same reply with crc_ok=0 → no learn_strobe.
- cfg write to entry 0 during a packet targeting the old address → old packet matches (strobe). After h_data falls the new value applies, and the next packet to the old address gets no strobe.
- rst asserted at byte 30 of a matching request → no strobe for that packet. The following identical packet gets a normal strobe/ok. A 40-byte truncated request → no strobe.

Source files
------------

// File: rtl/arp_pkg.sv
// ARP frame layout, template constants and arp_bus field positions shared by
// the ARP receive matcher and the ARP transmitter.
package arp_pkg;

  localparam logic [5:0] ETHERTYPE_OFF = 6'd12;
  localparam logic [5:0] HTYPE_OFF     = 6'd14;
  localparam logic [5:0] PTYPE_OFF     = 6'd16;
  localparam logic [5:0] HLEN_OFF      = 6'd18;
  localparam logic [5:0] PLEN_OFF      = 6'd19;
  localparam logic [5:0] OPER_OFF      = 6'd20;
  localparam logic [5:0] SHA_OFF       = 6'd22;
  localparam logic [5:0] SPA_OFF       = 6'd28;
  localparam logic [5:0] TPA_OFF       = 6'd38;
  localparam logic [5:0] MIN_LEN       = 6'd42;
  localparam logic [5:0] CNT_MAX       = 6'd63;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN_ETH      = 8'd6;
  localparam logic [7:0]  PLEN_IPV4     = 8'd4;
  localparam logic [7:0]  OPER_REQ      = 8'h01;
  localparam logic [7:0]  OPER_REP      = 8'h02;

  // arp_bus = {ok, strobe, write, data[7:0], idx}; offsets are above the idx field
  localparam int BUS_DATA_OFF   = 0;
  localparam int BUS_WRITE_OFF  = 8;
  localparam int BUS_STROBE_OFF = 9;
  localparam int BUS_OK_OFF     = 10;
  localparam int BUS_FIXED_W    = 11;

  // Fixed header octets up to the high opcode byte; other offsets always pass.
  function automatic logic template_ok(input logic [5:0] cnt, input logic [7:0] d);
    case (cnt)
      ETHERTYPE_OFF:         template_ok = (d == ETHERTYPE_ARP[15:8]);
      ETHERTYPE_OFF + 6'd1:  template_ok = (d == ETHERTYPE_ARP[7:0]);
      HTYPE_OFF:             template_ok = (d == HTYPE_ETH[15:8]);
      HTYPE_OFF + 6'd1:      template_ok = (d == HTYPE_ETH[7:0]);
      PTYPE_OFF:             template_ok = (d == PTYPE_IPV4[15:8]);
      PTYPE_OFF + 6'd1:      template_ok = (d == PTYPE_IPV4[7:0]);
      HLEN_OFF:              template_ok = (d == HLEN_ETH);
      PLEN_OFF:              template_ok = (d == PLEN_IPV4);
      OPER_OFF:              template_ok = (d == 8'h00);
      default:               template_ok = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/arp_ip_table.sv
// Local IPv4 address table with deferred configuration writes and a per-entry
// target-protocol-address match vector.
module arp_ip_table
  import arp_pkg::*;
#(
  parameter int           N_IP    = 2,
  parameter int           IDX_W   = 2,
  parameter logic [127:0] IP_INIT = {4{8'd192, 8'd168, 8'd7, 8'd2}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_data,
  input  logic             cfg_we,
  input  logic [IDX_W+1:0] cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             start,
  input  logic             cmp_en,
  input  logic [1:0]       cmp_octet,
  input  logic [7:0]       cmp_data,
  output logic [N_IP-1:0]  m
);

  localparam int AW = IDX_W + 2;

  logic          pend_valid_reg;
  logic [AW-1:0] pend_addr_reg;
  logic [7:0]    pend_data_reg;
  logic [N_IP*32-1:0] ip_flat;

  // Writes arriving mid-packet wait here so a packet sees a stable table.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= 8'h00;
    end else if (h_data) begin
      if (cfg_we) begin
        pend_valid_reg <= 1'b1;
        pend_addr_reg  <= cfg_addr;
        pend_data_reg  <= cfg_data;
      end
    end else begin
      pend_valid_reg <= 1'b0;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_IP; gi++) begin : g_entry
      logic [31:0] word;
      logic        m_bit_reg;

      for (gj = 0; gj < 4; gj++) begin : g_octet
        localparam logic [AW-1:0] ADDR = AW'(gi * 4 + gj);
        logic [7:0] octet_reg;
        logic       direct_we;
        logic       pend_we;

        assign direct_we = cfg_we & ~h_data & (cfg_addr == ADDR);
        assign pend_we   = pend_valid_reg & ~h_data & (pend_addr_reg == ADDR);

        always_ff @(posedge clk) begin
          if (rst)            octet_reg <= IP_INIT[32*gi + 8*(3-gj) +: 8];
          else if (direct_we) octet_reg <= cfg_data;
          else if (pend_we)   octet_reg <= pend_data_reg;
        end

        assign ip_flat[32*gi + 8*(3-gj) +: 8] = octet_reg;
      end

      assign word = ip_flat[32*gi +: 32];

      // Octet 0 is the most significant byte of the word.
      always_ff @(posedge clk) begin
        if (rst)
          m_bit_reg <= 1'b0;
        else if (start)
          m_bit_reg <= 1'b1;
        else if (cmp_en && (word[{~cmp_octet, 3'b000} +: 8] != cmp_data))
          m_bit_reg <= 1'b0;
      end

      assign m[gi] = m_bit_reg;
    end
  endgenerate

endmodule

// File: rtl/arp_rx_multi.sv
// ARP receive matcher: checks the ARP template, matches the target address
// against N_IP local addresses, forwards sender bytes and reports replies.
module arp_rx_multi
  import arp_pkg::*;
#(
  parameter int           N_IP    = 2,
  parameter int           IDX_W   = 2,
  parameter logic [127:0] IP_INIT = {4{8'd192, 8'd168, 8'd7, 8'd2}},
  parameter int           LEARN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              h_data,
  input  logic              crc_strobe,
  input  logic              crc_ok,
  input  logic              cfg_we,
  input  logic [IDX_W+1:0]  cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [IDX_W+10:0] arp_bus,
  output logic              learn_strobe,
  output logic [47:0]       learn_mac,
  output logic [31:0]       learn_ip
);

  logic             h_data1_reg;
  logic [5:0]       pack_cnt_reg;
  logic             keep_reg, is_reply_reg, len_ok_reg;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [79:0]      sender_reg;
  logic [7:0]       d1_reg, data_reg;
  logic             wr1_reg, write_reg, strobe_reg, ok_reg;
  logic [N_IP-1:0]  m;
  logic             start, in_sender, in_tpa, decide;
  logic [1:0]       cmp_octet;

  assign start     = h_data & ~h_data1_reg;
  assign in_sender = h_data && (pack_cnt_reg >= SHA_OFF) && (pack_cnt_reg <= SPA_OFF + 6'd3);
  assign in_tpa    = h_data && (pack_cnt_reg >= TPA_OFF) && (pack_cnt_reg <= TPA_OFF + 6'd3);
  assign cmp_octet = pack_cnt_reg[1:0] - TPA_OFF[1:0];
  assign decide    = crc_strobe & keep_reg & (|m) & len_ok_reg;

  arp_ip_table #(
    .N_IP    (N_IP),
    .IDX_W   (IDX_W),
    .IP_INIT (IP_INIT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .h_data    (h_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .cmp_en    (in_tpa),
    .cmp_octet (cmp_octet),
    .cmp_data  (data),
    .m         (m)
  );

  always_comb begin
    idx_next = '0;
    for (int i = N_IP - 1; i >= 0; i--)
      if (m[i]) idx_next = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Treat h_data as already high so a packet cut by reset is never restarted.
      h_data1_reg  <= 1'b1;
      pack_cnt_reg <= 6'd0;
      keep_reg     <= 1'b0;
      is_reply_reg <= 1'b0;
      len_ok_reg   <= 1'b0;
      idx_reg      <= '0;
      sender_reg   <= 80'd0;
      d1_reg       <= 8'h00;
      wr1_reg      <= 1'b0;
      write_reg    <= 1'b0;
      data_reg     <= 8'h00;
      strobe_reg   <= 1'b0;
      ok_reg       <= 1'b0;
    end else begin
      h_data1_reg <= h_data;

      if (!h_data)                    pack_cnt_reg <= 6'd0;
      else if (pack_cnt_reg != CNT_MAX) pack_cnt_reg <= pack_cnt_reg + 6'd1;

      if (start) begin
        keep_reg     <= 1'b1;
        is_reply_reg <= 1'b0;
        len_ok_reg   <= 1'b0;
      end else begin
        if (h_data && !template_ok(pack_cnt_reg, data))
          keep_reg <= 1'b0;
        if (h_data && (pack_cnt_reg == OPER_OFF + 6'd1)) begin
          if (data == OPER_REP)      is_reply_reg <= 1'b1;
          else if (data == OPER_REQ) is_reply_reg <= 1'b0;
          else                       keep_reg     <= 1'b0;
        end
        // The CRC result consumes this packet's decision state.
        if (crc_strobe)
          keep_reg <= 1'b0;
        if (pack_cnt_reg >= MIN_LEN)
          len_ok_reg <= 1'b1;
      end

      if ((pack_cnt_reg == MIN_LEN) && !len_ok_reg)
        idx_reg <= idx_next;

      if (in_sender)
        sender_reg <= {sender_reg[71:0], data};

      d1_reg    <= data;
      wr1_reg   <= in_sender & keep_reg & ~is_reply_reg;
      write_reg <= wr1_reg;
      data_reg  <= wr1_reg ? d1_reg : 8'h00;

      strobe_reg <= decide & ~is_reply_reg;
      ok_reg     <= decide & ~is_reply_reg & crc_ok;
    end
  end

  assign arp_bus = {ok_reg, strobe_reg, write_reg, data_reg, idx_reg};

  generate
    if (LEARN != 0) begin : g_learn
      logic        learn_strobe_reg;
      logic [47:0] learn_mac_reg;
      logic [31:0] learn_ip_reg;
      logic        learn_hit;

      assign learn_hit = decide & is_reply_reg & crc_ok;

      always_ff @(posedge clk) begin
        if (rst) begin
          learn_strobe_reg <= 1'b0;
          learn_mac_reg    <= 48'd0;
          learn_ip_reg     <= 32'd0;
        end else begin
          learn_strobe_reg <= learn_hit;
          if (learn_hit) begin
            learn_mac_reg <= sender_reg[79:32];
            learn_ip_reg  <= sender_reg[31:0];
          end
        end
      end

      assign learn_strobe = learn_strobe_reg;
      assign learn_mac    = learn_mac_reg;
      assign learn_ip     = learn_ip_reg;
    end else begin : g_no_learn
      assign learn_strobe = 1'b0;
      assign learn_mac    = 48'd0;
      assign learn_ip     = 32'd0;
    end
  endgenerate

endmodule
